alu_op_issuer: RTL and testbench

//   Initiator side of the ALU operand/control interface: accepts one encoded ALU request at a time,

---
 rtl/alu_op_issuer_if.sv | 37 +++
 rtl/alu_op_issuer.sv | 168 ++++++++++++++++
 tb/tb_alu_op_issuer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_issuer_if.sv
// -----------------------------------------------------------------------------
// alu_op_issuer_if
// Bundles the three handshakes around the ALU operation issuer:
//   request  : req_valid/req_ready with req_op, req_a, req_b (sequencer -> issuer)
//   ALU bus  : alu_ctrl, alu_a, alu_b out and alu_zlow, alu_zhigh back (issuer <-> ALU)
//   response : rsp_valid/rsp_ready with rsp_zlow, rsp_zhigh, rsp_err (issuer -> consumer)
// Modports:
//   master : the issuer itself (it initiates ALU operations and owns the response)
//   slave  : the surrounding environment (sequencer, ALU and response consumer)
// -----------------------------------------------------------------------------
interface alu_op_issuer_if;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [11:0] alu_ctrl;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_zlow;
   logic [31:0] alu_zhigh;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_zlow;
   logic [31:0] rsp_zhigh;
   logic        rsp_err;

   modport master (
      input  req_valid, req_op, req_a, req_b, alu_zlow, alu_zhigh, rsp_ready,
      output req_ready, alu_ctrl, alu_a, alu_b, rsp_valid, rsp_zlow, rsp_zhigh, rsp_err
   );

   modport slave (
      output req_valid, req_op, req_a, req_b, alu_zlow, alu_zhigh, rsp_ready,
      input  req_ready, alu_ctrl, alu_a, alu_b, rsp_valid, rsp_zlow, rsp_zhigh, rsp_err
   );
endinterface

// File: rtl/alu_op_issuer.sv
// -----------------------------------------------------------------------------
// alu_op_issuer
// Initiator side of the ALU operand/control interface. Accepts one encoded ALU
// request at a time, drives the one-hot 12-bit control word and the A/B operands
// for a per-op settle time, captures the 64-bit zhigh:zlow result and returns it
// on a valid/ready response port. Illegal ops (12..15) bypass the ALU and return
// an error response with zero results.
// Ports:
//   clock      : rising-edge clock
//   clear      : synchronous active-high reset, overrides every other input
//   bus        : alu_op_issuer_if.master (request, ALU bus, response)
//   done_count : number of completed response handshakes, wraps to 0
// Parameters:
//   SETTLE_CYCLES : cycles the ALU is driven for single-cycle ops (>=1)
//   MULDIV_CYCLES : cycles the ALU is driven for MUL (op 2) and DIV (op 3) (>=1)
//   CNT_W         : width of done_count
// -----------------------------------------------------------------------------
module alu_op_issuer #(
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter int unsigned MULDIV_CYCLES = 4,
   parameter int unsigned CNT_W         = 16
) (
   input  logic             clock,
   input  logic             clear,
   alu_op_issuer_if.master  bus,
   output logic [CNT_W-1:0] done_count
);

   localparam int unsigned MAX_CYC = (SETTLE_CYCLES > MULDIV_CYCLES) ? SETTLE_CYCLES : MULDIV_CYCLES;
   localparam int unsigned TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   // The timer is loaded with N-1 so that the ALU is driven for exactly N cycles.
   localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
   localparam logic [TMR_W-1:0] MULDIV_LOAD = TMR_W'(MULDIV_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   state_t           state_q,      state_d;
   logic [TMR_W-1:0] tmr_q,        tmr_d;
   logic             req_ready_q,  req_ready_d;
   logic [11:0]      alu_ctrl_q,   alu_ctrl_d;
   logic [31:0]      alu_a_q,      alu_a_d;
   logic [31:0]      alu_b_q,      alu_b_d;
   logic             rsp_valid_q,  rsp_valid_d;
   logic [31:0]      rsp_zlow_q,   rsp_zlow_d;
   logic [31:0]      rsp_zhigh_q,  rsp_zhigh_d;
   logic             rsp_err_q,    rsp_err_d;
   logic [CNT_W-1:0] done_count_q, done_count_d;

   // Next-state and next-output computation for the IDLE/DRIVE/RESP sequencer.
   always_comb begin
      state_d      = state_q;
      tmr_d        = tmr_q;
      req_ready_d  = req_ready_q;
      alu_ctrl_d   = alu_ctrl_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_zlow_d   = rsp_zlow_q;
      rsp_zhigh_d  = rsp_zhigh_q;
      rsp_err_d    = rsp_err_q;
      done_count_d = done_count_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid && req_ready_q) begin
               req_ready_d = 1'b0;
               if (bus.req_op <= 4'd11) begin
                  state_d    = ST_DRIVE;
                  alu_ctrl_d = 12'd1 << bus.req_op;
                  alu_a_d    = bus.req_a;
                  alu_b_d    = bus.req_b;
                  if ((bus.req_op == 4'd2) || (bus.req_op == 4'd3)) begin
                     tmr_d = MULDIV_LOAD;
                  end else begin
                     tmr_d = SETTLE_LOAD;
                  end
               end else begin
                  // Illegal op: never touch the ALU, answer with an error at once.
                  state_d     = ST_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_zlow_d  = 32'd0;
                  rsp_zhigh_d = 32'd0;
               end
            end else begin
               req_ready_d = 1'b1;
            end
         end

         ST_DRIVE: begin
            if (tmr_q != {TMR_W{1'b0}}) begin
               tmr_d = tmr_q - TMR_W'(1);
            end else begin
               // Settle time elapsed: sample the ALU result and release the control word.
               state_d     = ST_RESP;
               alu_ctrl_d  = 12'd0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_zlow_d  = bus.alu_zlow;
               rsp_zhigh_d = bus.alu_zhigh;
            end
         end

         ST_RESP: begin
            if (rsp_valid_q && bus.rsp_ready) begin
               state_d      = ST_IDLE;
               rsp_valid_d  = 1'b0;
               req_ready_d  = 1'b1;
               done_count_d = done_count_q + CNT_W'(1);
            end else begin
               rsp_valid_d = 1'b1;
            end
         end

         default: begin
            state_d     = ST_IDLE;
            req_ready_d = 1'b1;
            alu_ctrl_d  = 12'd0;
            rsp_valid_d = 1'b0;
         end
      endcase
   end

   // State and registered-output flops with synchronous clear.
   always_ff @(posedge clock) begin
      if (clear) begin
         state_q      <= ST_IDLE;
         tmr_q        <= {TMR_W{1'b0}};
         req_ready_q  <= 1'b1;
         alu_ctrl_q   <= 12'd0;
         alu_a_q      <= 32'd0;
         alu_b_q      <= 32'd0;
         rsp_valid_q  <= 1'b0;
         rsp_zlow_q   <= 32'd0;
         rsp_zhigh_q  <= 32'd0;
         rsp_err_q    <= 1'b0;
         done_count_q <= {CNT_W{1'b0}};
      end else begin
         state_q      <= state_d;
         tmr_q        <= tmr_d;
         req_ready_q  <= req_ready_d;
         alu_ctrl_q   <= alu_ctrl_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_zlow_q   <= rsp_zlow_d;
         rsp_zhigh_q  <= rsp_zhigh_d;
         rsp_err_q    <= rsp_err_d;
         done_count_q <= done_count_d;
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.alu_ctrl  = alu_ctrl_q;
   assign bus.alu_a     = alu_a_q;
   assign bus.alu_b     = alu_b_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_zlow  = rsp_zlow_q;
   assign bus.rsp_zhigh = rsp_zhigh_q;
   assign bus.rsp_err   = rsp_err_q;
   assign done_count    = done_count_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_issuer
// Directed bench for alu_op_issuer with a behavioural ALU attached to the ALU
// bus. Each scenario task drives its own stimulus and compares against
// hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_alu_op_issuer;

   logic        clock = 1'b0;
   logic        clear;
   logic [15:0] done_count;
   int          checks = 0;
   int          errors = 0;

   alu_op_issuer_if bus ();

   alu_op_issuer #(
      .SETTLE_CYCLES (1),
      .MULDIV_CYCLES (4),
      .CNT_W         (16)
   ) dut (
      .clock      (clock),
      .clear      (clear),
      .bus        (bus),
      .done_count (done_count)
   );

   // Free-running clock, 10 time units per period.
   always #5 clock = ~clock;

   logic [63:0] mul_p;
   logic [4:0]  sh;
   logic [63:0] aa;
   assign mul_p = $signed({{32{bus.alu_a[31]}}, bus.alu_a}) * $signed({{32{bus.alu_b[31]}}, bus.alu_b});
   assign sh    = bus.alu_b[4:0];
   assign aa    = {bus.alu_a, bus.alu_a};

   // Behavioural combinational ALU responding to the one-hot control word.
   always_comb begin
      bus.alu_zlow  = 32'd0;
      bus.alu_zhigh = 32'd0;
      case (bus.alu_ctrl)
         12'h001: bus.alu_zlow = bus.alu_a + bus.alu_b;
         12'h002: bus.alu_zlow = bus.alu_a - bus.alu_b;
         12'h004: begin
            bus.alu_zlow  = mul_p[31:0];
            bus.alu_zhigh = mul_p[63:32];
         end
         12'h008: begin
            if (bus.alu_b != 32'd0) begin
               bus.alu_zlow  = $signed(bus.alu_a) / $signed(bus.alu_b);
               bus.alu_zhigh = $signed(bus.alu_a) % $signed(bus.alu_b);
            end else begin
               bus.alu_zlow  = 32'd0;
            end
         end
         12'h010: bus.alu_zlow = bus.alu_a >> sh;
         12'h020: bus.alu_zlow = bus.alu_a << sh;
         12'h040: bus.alu_zlow = 32'(aa >> sh);
         12'h080: bus.alu_zlow = 32'((aa << sh) >> 32);
         12'h100: bus.alu_zlow = bus.alu_a & bus.alu_b;
         12'h200: bus.alu_zlow = bus.alu_a | bus.alu_b;
         12'h400: bus.alu_zlow = 32'd0 - bus.alu_a;
         12'h800: bus.alu_zlow = ~bus.alu_a;
         default: bus.alu_zlow = 32'd0;
      endcase
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      clear         = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_op    = 4'd0;
      bus.req_a     = 32'd0;
      bus.req_b     = 32'd0;
      bus.rsp_ready = 1'b0;
      step();
      step();
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
      checks++; if (bus.alu_ctrl !== 12'h000) begin errors++; $display("FAIL reset_alu_ctrl got %h want 000", bus.alu_ctrl); end
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
      checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b want 0", bus.rsp_err); end
      checks++; if (done_count !== 16'd0) begin errors++; $display("FAIL reset_done_count got %0d want 0", done_count); end
      checks++; if (bus.alu_a !== 32'd0) begin errors++; $display("FAIL reset_alu_a got %h want 0", bus.alu_a); end
      clear = 1'b0;
   endtask

   task automatic test_add();
      bus.rsp_ready = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_op    = 4'd0;
      bus.req_a     = 32'd5;
      bus.req_b     = 32'd7;
      step();
      checks++; if (bus.alu_ctrl !== 12'h001) begin errors++; $display("FAIL add_ctrl got %h want 001", bus.alu_ctrl); end
      checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL add_req_ready got %b want 0", bus.req_ready); end
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL add_early_valid got %b want 0", bus.rsp_valid); end
      checks++; if ((bus.alu_a !== 32'd5) || (bus.alu_b !== 32'd7)) begin errors++; $display("FAIL add_operands got %h/%h want 5/7", bus.alu_a, bus.alu_b); end
      bus.req_valid = 1'b0;
      step();
      checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL add_rsp_valid got %b want 1", bus.rsp_valid); end
      checks++; if (bus.alu_ctrl !== 12'h000) begin errors++; $display("FAIL add_ctrl_off got %h want 000", bus.alu_ctrl); end
      checks++; if (bus.rsp_zlow !== 32'd12) begin errors++; $display("FAIL add_zlow got %0d want 12", bus.rsp_zlow); end
      checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL add_err got %b want 0", bus.rsp_err); end
      checks++; if ((bus.alu_a !== 32'd5) || (bus.alu_b !== 32'd7)) begin errors++; $display("FAIL add_operands_kept got %h/%h want 5/7", bus.alu_a, bus.alu_b); end
      step();
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL add_rsp_drop got %b want 0", bus.rsp_valid); end
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL add_ready_back got %b want 1", bus.req_ready); end
      checks++; if (done_count !== 16'd1) begin errors++; $display("FAIL add_done_count got %0d want 1", done_count); end
   endtask

   task automatic test_mul();
      int ncyc;
      int active;
      ncyc   = 0;
      active = 0;
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_op    = 4'd2;
      bus.req_a     = 32'd3;
      bus.req_b     = 32'hFFFF_FFFE;
      step();
      bus.req_valid = 1'b0;
      while ((bus.rsp_valid !== 1'b1) && (ncyc < 20)) begin
         if (bus.alu_ctrl === 12'h004) active++;
         ncyc++;
         step();
      end
      checks++; if (ncyc !== 4) begin errors++; $display("FAIL mul_latency got %0d want 4", ncyc); end
      checks++; if (active !== 4) begin errors++; $display("FAIL mul_ctrl_cycles got %0d want 4", active); end
      checks++; if (bus.rsp_zlow !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mul_zlow got %h want fffffffa", bus.rsp_zlow); end
      checks++; if (bus.rsp_zhigh !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mul_zhigh got %h want ffffffff", bus.rsp_zhigh); end
      checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL mul_err got %b want 0", bus.rsp_err); end
      step();
      checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL mul_hold_valid got %b want 1", bus.rsp_valid); end
      bus.rsp_ready = 1'b1;
      step();
      checks++; if (done_count !== 16'd2) begin errors++; $display("FAIL mul_done_count got %0d want 2", done_count); end
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_illegal();
      bus.req_valid = 1'b1;
      bus.req_op    = 4'd13;
      bus.req_a     = 32'h1111_1111;
      bus.req_b     = 32'h2222_2222;
      step();
      bus.req_valid = 1'b0;
      checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL ill_rsp_valid got %b want 1", bus.rsp_valid); end
      checks++; if (bus.rsp_err !== 1'b1) begin errors++; $display("FAIL ill_err got %b want 1", bus.rsp_err); end
      checks++; if ((bus.rsp_zlow !== 32'd0) || (bus.rsp_zhigh !== 32'd0)) begin errors++; $display("FAIL ill_results got %h/%h want 0/0", bus.rsp_zhigh, bus.rsp_zlow); end
      checks++; if (bus.alu_ctrl !== 12'h000) begin errors++; $display("FAIL ill_ctrl got %h want 000", bus.alu_ctrl); end
      checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL ill_req_ready got %b want 0", bus.req_ready); end
      bus.rsp_ready = 1'b1;
      step();
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL ill_rsp_drop got %b want 0", bus.rsp_valid); end
      checks++; if (done_count !== 16'd3) begin errors++; $display("FAIL ill_done_count got %0d want 3", done_count); end
      checks++; if (bus.alu_ctrl !== 12'h000) begin errors++; $display("FAIL ill_ctrl_after got %h want 000", bus.alu_ctrl); end
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_op    = 4'd5;
      bus.req_a     = 32'd1;
      bus.req_b     = 32'd4;
      step();
      checks++; if (bus.alu_ctrl !== 12'h020) begin errors++; $display("FAIL b2b_shl_ctrl got %h want 020", bus.alu_ctrl); end
      // Second request presented right away and held until accepted.
      bus.req_op = 4'd8;
      bus.req_a  = 32'h0000_00F0;
      bus.req_b  = 32'h0000_003C;
      step();
      checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_rsp_valid got %b want 1", bus.rsp_valid); end
      for (int i = 0; i < 5; i++) begin
         step();
         checks++; if (bus.rsp_zlow !== 32'd16) begin errors++; $display("FAIL b2b_hold_zlow cyc %0d got %0d want 16", i, bus.rsp_zlow); end
         checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_hold_ready cyc %0d got %b want 0", i, bus.req_ready); end
         checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_hold_valid cyc %0d got %b want 1", i, bus.rsp_valid); end
         checks++; if (bus.alu_ctrl !== 12'h000) begin errors++; $display("FAIL b2b_hold_ctrl cyc %0d got %h want 000", i, bus.alu_ctrl); end
      end
      bus.rsp_ready = 1'b1;
      step();
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_hs_valid got %b want 0", bus.rsp_valid); end
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_hs_ready got %b want 1", bus.req_ready); end
      checks++; if (bus.alu_ctrl !== 12'h000) begin errors++; $display("FAIL b2b_not_yet got %h want 000", bus.alu_ctrl); end
      checks++; if (done_count !== 16'd4) begin errors++; $display("FAIL b2b_done_count got %0d want 4", done_count); end
      step();
      checks++; if (bus.alu_ctrl !== 12'h100) begin errors++; $display("FAIL b2b_and_ctrl got %h want 100", bus.alu_ctrl); end
      bus.req_valid = 1'b0;
      step();
      checks++; if (bus.rsp_zlow !== 32'h0000_0030) begin errors++; $display("FAIL b2b_and_zlow got %h want 30", bus.rsp_zlow); end
      step();
      checks++; if (done_count !== 16'd5) begin errors++; $display("FAIL b2b_done_count2 got %0d want 5", done_count); end
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_clear_abort();
      int seen;
      seen = 0;
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_op    = 4'd3;
      bus.req_a     = 32'd100;
      bus.req_b     = 32'd7;
      step();
      checks++; if (bus.alu_ctrl !== 12'h008) begin errors++; $display("FAIL abort_div_ctrl got %h want 008", bus.alu_ctrl); end
      bus.req_valid = 1'b0;
      step();
      checks++; if (bus.alu_ctrl !== 12'h008) begin errors++; $display("FAIL abort_div_ctrl2 got %h want 008", bus.alu_ctrl); end
      clear = 1'b1;
      step();
      clear = 1'b0;
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL abort_req_ready got %b want 1", bus.req_ready); end
      checks++; if (bus.alu_ctrl !== 12'h000) begin errors++; $display("FAIL abort_ctrl got %h want 000", bus.alu_ctrl); end
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_rsp_valid got %b want 0", bus.rsp_valid); end
      checks++; if (done_count !== 16'd0) begin errors++; $display("FAIL abort_done_count got %0d want 0", done_count); end
      checks++; if (bus.alu_a !== 32'd0) begin errors++; $display("FAIL abort_alu_a got %h want 0", bus.alu_a); end
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         if ((bus.rsp_valid !== 1'b0) || (bus.alu_ctrl !== 12'h000)) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL abort_ghost_activity got %0d want 0", seen); end
      checks++; if (done_count !== 16'd0) begin errors++; $display("FAIL abort_done_after got %0d want 0", done_count); end
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_wrap();
      force dut.done_count_q = 16'hFFFF;
      step();
      release dut.done_count_q;
      step();
      checks++; if (done_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload got %h want ffff", done_count); end
      bus.rsp_ready = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_op    = 4'd11;
      bus.req_a     = 32'h1234_5678;
      bus.req_b     = 32'd0;
      step();
      bus.req_valid = 1'b0;
      checks++; if (bus.alu_ctrl !== 12'h800) begin errors++; $display("FAIL wrap_not_ctrl got %h want 800", bus.alu_ctrl); end
      step();
      checks++; if (bus.rsp_zlow !== 32'hEDCB_A987) begin errors++; $display("FAIL wrap_not_zlow got %h want edcba987", bus.rsp_zlow); end
      step();
      checks++; if (done_count !== 16'h0000) begin errors++; $display("FAIL wrap_done_count got %h want 0000", done_count); end
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL wrap_rsp_drop got %b want 0", bus.rsp_valid); end
      bus.rsp_ready = 1'b0;
   endtask

   // Scenario sequence and summary.
   initial begin
      test_reset();
      test_add();
      test_mul();
      test_illegal();
      test_back_to_back();
      test_clear_abort();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard time limit so the run always terminates.
   initial begin
      #100000;
      $display("FAIL timeout checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

endmodule
